reg_f_arb: RTL and testbench



---
 rtl/reg_f_arb_if.sv | 46 ++++
 rtl/reg_f_arb.sv | 140 ++++++++++++++
 tb/tb_reg_f_arb.sv | 222 ++++++++++++++++++++++
 3 files changed

// File: rtl/reg_f_arb_if.sv
// Bus bundle between the two requesters / register file and the reg_f_arb sequencer.
// The master side is the requesters plus the file's read port; the slave side is the arbiter.
interface reg_f_arb_if #(
    parameter int WIDTH  = 8,
    parameter int ADDR_W = 4
);
    logic              req_a;
    logic              we_a;
    logic [ADDR_W-1:0] addr_a;
    logic [WIDTH-1:0]  wdata_a;
    logic              gnt_a;
    logic              rvalid_a;
    logic [WIDTH-1:0]  rdata_a;

    logic              req_b;
    logic              we_b;
    logic [ADDR_W-1:0] addr_b;
    logic [WIDTH-1:0]  wdata_b;
    logic              gnt_b;
    logic              rvalid_b;
    logic [WIDTH-1:0]  rdata_b;

    logic              rf_en;
    logic [ADDR_W-1:0] rf_sel;
    logic [WIDTH-1:0]  rf_in;
    logic [WIDTH-1:0]  rf_out;
    logic              busy;

    modport master (
        output req_a, we_a, addr_a, wdata_a,
        output req_b, we_b, addr_b, wdata_b,
        output rf_out,
        input  gnt_a, rvalid_a, rdata_a,
        input  gnt_b, rvalid_b, rdata_b,
        input  rf_en, rf_sel, rf_in, busy
    );

    modport slave (
        input  req_a, we_a, addr_a, wdata_a,
        input  req_b, we_b, addr_b, wdata_b,
        input  rf_out,
        output gnt_a, rvalid_a, rdata_a,
        output gnt_b, rvalid_b, rdata_b,
        output rf_en, rf_sel, rf_in, busy
    );
endinterface

// File: rtl/reg_f_arb.sv
// Round-robin two-requester sequencer for the single-ported register file: one access per
// cycle, combinational grant/issue, read data returned one cycle after the grant.
module reg_f_arb #(
    parameter int WIDTH  = 8,
    parameter int SIZE   = 9,
    parameter int ADDR_W = $clog2(SIZE)
) (
    input logic         CLK,
    input logic         RST,
    reg_f_arb_if.slave  bus
);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RESP = 1'b1
    } state_t;

    state_t            state_r;
    state_t            state_s;
    logic              last_r;
    logic              pend_id_r;
    logic              pend_id_s;
    logic [ADDR_W-1:0] sel_hold_r;
    logic [WIDTH-1:0]  in_hold_r;
    logic [WIDTH-1:0]  rdata_a_r;
    logic [WIDTH-1:0]  rdata_b_r;

    logic              gnt_a_s;
    logic              gnt_b_s;
    logic              grant_s;
    logic              win_s;
    logic              we_w_s;
    logic [ADDR_W-1:0] addr_w_s;
    logic [WIDTH-1:0]  wdata_w_s;
    logic              rf_en_s;
    logic [ADDR_W-1:0] rf_sel_s;
    logic [WIDTH-1:0]  rf_in_s;
    logic              rvalid_a_s;
    logic              rvalid_b_s;

    // Arbitration, issue steering and response gating; RST suppresses grants and responses
    always_comb begin
        gnt_a_s    = 1'b0;
        gnt_b_s    = 1'b0;
        win_s      = 1'b0;
        if (RST) begin
            win_s = 1'b0;
        end else if (bus.req_a && bus.req_b) begin
            win_s   = ~last_r;
            gnt_a_s = last_r;
            gnt_b_s = ~last_r;
        end else if (bus.req_a) begin
            gnt_a_s = 1'b1;
        end else if (bus.req_b) begin
            win_s   = 1'b1;
            gnt_b_s = 1'b1;
        end else begin
            win_s = 1'b0;
        end
        grant_s = gnt_a_s | gnt_b_s;

        we_w_s    = win_s ? bus.we_b    : bus.we_a;
        addr_w_s  = win_s ? bus.addr_b  : bus.addr_a;
        wdata_w_s = win_s ? bus.wdata_b : bus.wdata_a;

        // SEL/IN hold between grants so the file sees a stable bus; EN never fires without a grant
        if (grant_s) begin
            rf_en_s  = we_w_s;
            rf_sel_s = addr_w_s;
            rf_in_s  = wdata_w_s;
        end else begin
            rf_en_s  = 1'b0;
            rf_sel_s = sel_hold_r;
            rf_in_s  = in_hold_r;
        end

        rvalid_a_s = (state_r == ST_RESP) && !pend_id_r && !RST;
        rvalid_b_s = (state_r == ST_RESP) &&  pend_id_r && !RST;
    end

    // Next-state: a granted read leaves a response in flight for exactly one cycle
    always_comb begin
        state_s   = state_r;
        pend_id_s = pend_id_r;
        case (state_r)
            ST_IDLE, ST_RESP: begin
                if (grant_s && !we_w_s) begin
                    state_s   = ST_RESP;
                    pend_id_s = win_s;
                end else begin
                    state_s   = ST_IDLE;
                    pend_id_s = pend_id_r;
                end
            end
            default: begin
                state_s   = ST_IDLE;
                pend_id_s = 1'b0;
            end
        endcase
    end

    // State, round-robin pointer, bus hold registers and captured read data
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_r    <= ST_IDLE;
            last_r     <= 1'b1;
            pend_id_r  <= 1'b0;
            sel_hold_r <= {ADDR_W{1'b0}};
            in_hold_r  <= {WIDTH{1'b0}};
            rdata_a_r  <= {WIDTH{1'b0}};
            rdata_b_r  <= {WIDTH{1'b0}};
        end else begin
            state_r   <= state_s;
            pend_id_r <= pend_id_s;
            if (grant_s) begin
                last_r     <= win_s;
                sel_hold_r <= rf_sel_s;
                in_hold_r  <= rf_in_s;
            end
            if (rvalid_a_s) begin
                rdata_a_r <= bus.rf_out;
            end
            if (rvalid_b_s) begin
                rdata_b_r <= bus.rf_out;
            end
        end
    end

    assign bus.gnt_a    = gnt_a_s;
    assign bus.gnt_b    = gnt_b_s;
    assign bus.rf_en    = rf_en_s;
    assign bus.rf_sel   = rf_sel_s;
    assign bus.rf_in    = rf_in_s;
    assign bus.rvalid_a = rvalid_a_s;
    assign bus.rvalid_b = rvalid_b_s;
    assign bus.rdata_a  = rvalid_a_s ? bus.rf_out : rdata_a_r;
    assign bus.rdata_b  = rvalid_b_s ? bus.rf_out : rdata_b_r;
    assign bus.busy     = (state_r == ST_RESP);

endmodule

// File: tb/tb_reg_f_arb.sv
// Bench for reg_f_arb: directed scenarios plus random traffic from two requesters, checked
// each cycle against a transaction-level model (shadow register contents, round-robin rule).
module tb_reg_f_arb;
    localparam int WIDTH  = 8;
    localparam int SIZE   = 9;
    localparam int ADDR_W = 4;

    logic CLK = 1'b0;
    logic RST;
    always #5 CLK = ~CLK;

    reg_f_arb_if #(.WIDTH(WIDTH), .ADDR_W(ADDR_W)) bus ();

    reg_f_arb #(.WIDTH(WIDTH), .SIZE(SIZE), .ADDR_W(ADDR_W)) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus)
    );

    // Register file: write on EN, OUT registered every cycle, all-ones select is the I/O port
    logic [7:0] rf_mem [0:SIZE-1];
    logic [7:0] rf_port;
    logic [7:0] rf_out_q;
    logic       file_clr;
    assign bus.rf_out = rf_out_q;

    always @(posedge CLK) begin
        if (file_clr) begin
            for (int i = 0; i < SIZE; i++) rf_mem[i] <= 8'h00;
            rf_port  <= 8'h00;
            rf_out_q <= 8'h00;
        end else begin
            if (bus.rf_en) begin
                if (bus.rf_sel == 4'hF) rf_port <= bus.rf_in;
                else if (int'(bus.rf_sel) < SIZE) rf_mem[bus.rf_sel] <= bus.rf_in;
            end
            rf_out_q <= (bus.rf_sel == 4'hF) ? rf_port :
                        (int'(bus.rf_sel) < SIZE) ? rf_mem[bus.rf_sel] : 8'h00;
        end
    end

    int n_checks = 0;
    int n_fail   = 0;
    bit chk_en;

    // Reference state: what each requester should see, independent of the DUT's encoding
    int         last_m;
    bit         pend_m;
    bit         pend_own_m;
    logic [7:0] pend_data_m;
    logic [3:0] hold_sel_m;
    logic [7:0] hold_in_m;
    logic [7:0] rdata_a_m;
    logic [7:0] rdata_b_m;
    logic [7:0] shadow [0:15];
    bit         ga_m, gb_m;
    logic       obs_gnt_a, obs_gnt_b;

    task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        last_m      = 1;
        pend_m      = 1'b0;
        pend_own_m  = 1'b0;
        pend_data_m = 8'h00;
        hold_sel_m  = 4'h0;
        hold_in_m   = 8'h00;
        rdata_a_m   = 8'h00;
        rdata_b_m   = 8'h00;
    endtask

    // One clock cycle: drive, check combinational outputs at negedge, advance model at posedge
    task automatic step(input bit ra, input bit wa, input logic [3:0] aa, input logic [7:0] da,
                        input bit rb, input bit wb, input logic [3:0] ab, input logic [7:0] db,
                        input bit rst);
        bit         g, w, we_w, va, vb;
        logic [3:0] ad_w;
        logic [7:0] d_w;
        bus.req_a = ra; bus.we_a = wa; bus.addr_a = aa; bus.wdata_a = da;
        bus.req_b = rb; bus.we_b = wb; bus.addr_b = ab; bus.wdata_b = db;
        RST = rst;
        g    = !rst && (ra || rb);
        w    = (ra && rb) ? (last_m == 0) : rb;
        we_w = w ? wb : wa;
        ad_w = w ? ab : aa;
        d_w  = w ? db : da;
        va   = !rst && pend_m && !pend_own_m;
        vb   = !rst && pend_m &&  pend_own_m;
        ga_m = g && !w;
        gb_m = g && w;
        @(negedge CLK);
        obs_gnt_a = bus.gnt_a;
        obs_gnt_b = bus.gnt_b;
        if (chk_en) begin
            check_val("gnt_a", bus.gnt_a, ga_m);
            check_val("gnt_b", bus.gnt_b, gb_m);
            check_val("rf_en", bus.rf_en, g && we_w);
            check_val("rf_sel", bus.rf_sel, g ? ad_w : hold_sel_m);
            check_val("rf_in", bus.rf_in, g ? d_w : hold_in_m);
            check_val("rvalid_a", bus.rvalid_a, va);
            check_val("rvalid_b", bus.rvalid_b, vb);
            check_val("rdata_a", bus.rdata_a, va ? pend_data_m : rdata_a_m);
            check_val("rdata_b", bus.rdata_b, vb ? pend_data_m : rdata_b_m);
            check_val("busy", bus.busy, pend_m);
        end
        @(posedge CLK);
        if (rst) begin
            model_reset();
        end else begin
            if (va) rdata_a_m = pend_data_m;
            if (vb) rdata_b_m = pend_data_m;
            pend_m = 1'b0;
            if (g) begin
                last_m     = w;
                hold_sel_m = ad_w;
                hold_in_m  = d_w;
                if (we_w) begin
                    shadow[ad_w] = d_w;
                end else begin
                    pend_m      = 1'b1;
                    pend_own_m  = w;
                    pend_data_m = shadow[ad_w];
                end
            end
        end
        #1;
    endtask

    task automatic idle();
        step(1'b0, 1'b0, 4'h0, 8'h00, 1'b0, 1'b0, 4'h0, 8'h00, 1'b0);
    endtask

    function automatic logic [3:0] rnd_addr();
        int a;
        a = $urandom_range(0, 9);
        return (a == 9) ? 4'hF : 4'(a);
    endfunction

    initial begin
        int         cnt_a, cnt_b;
        bit         ra, wa, rb, wb;
        logic [3:0] aa, ab;
        logic [7:0] da, db;

        chk_en   = 1'b0;
        file_clr = 1'b1;
        for (int i = 0; i < 16; i++) shadow[i] = 8'h00;
        model_reset();
        step(1'b0, 1'b0, 4'h0, 8'h00, 1'b0, 1'b0, 4'h0, 8'h00, 1'b1);
        step(1'b0, 1'b0, 4'h0, 8'h00, 1'b0, 1'b0, 4'h0, 8'h00, 1'b1);
        file_clr = 1'b0;
        chk_en   = 1'b1;

        // Reset state, then A writes 0x5A to reg 3 and reads it back
        idle();
        step(1'b1, 1'b1, 4'd3, 8'h5A, 1'b0, 1'b0, 4'h0, 8'h00, 1'b0);
        check_val("wr_gnt_a", obs_gnt_a, 1'b1);
        step(1'b1, 1'b0, 4'd3, 8'h00, 1'b0, 1'b0, 4'h0, 8'h00, 1'b0);
        idle();

        // Continuous contention alternates the grant
        cnt_a = 0;
        cnt_b = 0;
        for (int i = 0; i < 8; i++) begin
            step(1'b1, 1'b0, 4'd1, 8'h00, 1'b1, 1'b1, 4'd2, 8'h11, 1'b0);
            cnt_a += int'(obs_gnt_a);
            cnt_b += int'(obs_gnt_b);
        end
        idle();
        check_val("alt_cnt_a", cnt_a, 4);
        check_val("alt_cnt_b", cnt_b, 4);

        // B writes 0x77 to reg 4, A reads it back on the very next cycle
        step(1'b0, 1'b0, 4'h0, 8'h00, 1'b1, 1'b1, 4'd4, 8'h77, 1'b0);
        step(1'b1, 1'b0, 4'd4, 8'h00, 1'b0, 1'b0, 4'h0, 8'h00, 1'b0);
        idle();

        // Reset lands on a pending read response; afterwards A wins the first tie
        step(1'b1, 1'b0, 4'd5, 8'h00, 1'b0, 1'b0, 4'h0, 8'h00, 1'b0);
        step(1'b0, 1'b0, 4'h0, 8'h00, 1'b0, 1'b0, 4'h0, 8'h00, 1'b1);
        idle();
        step(1'b1, 1'b0, 4'd0, 8'h00, 1'b1, 1'b0, 4'd1, 8'h00, 1'b0);
        check_val("tie_after_rst", obs_gnt_a, 1'b1);
        idle();

        // I/O port write through the all-ones select
        step(1'b1, 1'b1, 4'hF, 8'hC3, 1'b0, 1'b0, 4'h0, 8'h00, 1'b0);
        idle();
        idle();

        // Random traffic; a requester holds its request until granted
        ra = 1'b0; wa = 1'b0; aa = 4'h0; da = 8'h00;
        rb = 1'b0; wb = 1'b0; ab = 4'h0; db = 8'h00;
        for (int i = 0; i < 600; i++) begin
            if (!ra || ga_m) begin
                ra = ($urandom_range(0, 3) != 0);
                wa = 1'($urandom_range(0, 1));
                aa = rnd_addr();
                da = 8'($urandom);
            end
            if (!rb || gb_m) begin
                rb = ($urandom_range(0, 3) != 0);
                wb = 1'($urandom_range(0, 1));
                ab = rnd_addr();
                db = 8'($urandom);
            end
            step(ra, wa, aa, da, rb, wb, ab, db, 1'b0);
        end
        idle();
        idle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
